// File: rtl/shift_add_multiplier.sv
// shift_add_multiplier: sequential unsigned shift-and-add multiplier with early exit
// Ports:
//   clk_i          rising-edge clock
//   reset_ni       asynchronous active-low reset
//   multiplicand_i WIDTH-bit unsigned multiplicand, sampled on accepted start
//   multiplier_i   WIDTH-bit unsigned multiplier, sampled on accepted start
//   start_i        request, accepted only in IDLE
//   busy_o         high while iterating
//   finish_o       one-cycle completion pulse
//   product_o      2*WIDTH-bit product, held until the next accepted start
module shift_add_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic               clk_i,
    input  logic               reset_ni,
    input  logic [WIDTH-1:0]   multiplicand_i,
    input  logic [WIDTH-1:0]   multiplier_i,
    input  logic               start_i,
    output logic               busy_o,
    output logic               finish_o,
    output logic [2*WIDTH-1:0] product_o
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] BUSY   = 2'd1;
    localparam logic [1:0] FINISH = 2'd2;
    logic [1:0]         state;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state  <= IDLE;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else begin
            case (state)
                IDLE: if (start_i) begin
                    acc    <= '0;
                    mcand  <= {{WIDTH{1'b0}}, multiplicand_i};
                    mplier <= multiplier_i;
                    state  <= (multiplier_i != '0) ? BUSY : FINISH;
                end
                BUSY: begin
                    if (mplier[0]) acc <= acc + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    // exit once no set bits remain above the one consumed this cycle
                    if ((mplier >> 1) == '0) state <= FINISH;
                end
                FINISH: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
    assign busy_o    = (state == BUSY);
    assign finish_o  = (state == FINISH);
    assign product_o = acc;
endmodule
